// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS32 pipeline: load-use, branch, shared-memory wait, MEM exceptions.
// Optional HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W    = 6,
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src_a,
  input  logic [REG_W-1:0] id_src_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mem_conflict,
  input  logic             mem_ready,
  input  logic             exc_valid,
  output logic             pc_we,
  output logic             pc_sel_exc,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             memwb_clr,
  output logic             cp0_exc_we,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
`endif
  output logic             mem_err
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, EXC_FLUSH} state_t;

  typedef struct packed {
    logic pc_we, pc_sel_exc;
    logic ifid_we, idex_we, exmem_we, memwb_we;
    logic ifid_clr, idex_clr, exmem_clr, memwb_clr;
    logic cp0_exc_we, mem_err;
  } ctl_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wcnt, wcnt_nxt;
  ctl_t             ctl;
  logic             load_use;

  assign load_use = ex_mem_read && (ex_dest != '0) &&
                    ((id_use_a && id_src_a == ex_dest) || (id_use_b && id_src_b == ex_dest));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    ctl          = '0;
    ctl.pc_we    = 1'b1;
    ctl.ifid_we  = 1'b1;
    ctl.idex_we  = 1'b1;
    ctl.exmem_we = 1'b1;
    ctl.memwb_we = 1'b1;
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    case (state)
      RUN: begin
        if (exc_valid) begin
          ctl.pc_we = 1'b0;
          {ctl.ifid_clr, ctl.idex_clr, ctl.exmem_clr} = 3'b111;
          state_nxt = EXC_FLUSH;
        end else if (mem_conflict && !mem_ready) begin
          {ctl.pc_we, ctl.ifid_we, ctl.idex_we, ctl.exmem_we} = 4'b0000;
          ctl.memwb_clr = 1'b1;
          wcnt_nxt      = CNT_W'(1);
          state_nxt     = MEM_WAIT;
        end else if (branch_taken) begin
          // delay slot in IF/ID moves on; only the wrong-path fetch dies
          ctl.ifid_clr = 1'b1;
        end else if (load_use) begin
          ctl.pc_we    = 1'b0;
          ctl.ifid_we  = 1'b0;
          ctl.idex_clr = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (exc_valid || (!mem_ready && wcnt == CNT_W'(WAIT_MAX))) begin
          ctl.pc_we   = 1'b0;
          ctl.mem_err = !exc_valid;
          {ctl.ifid_clr, ctl.idex_clr, ctl.exmem_clr} = 3'b111;
          wcnt_nxt  = '0;
          state_nxt = EXC_FLUSH;
        end else if (mem_ready) begin
          wcnt_nxt  = '0;
          state_nxt = RUN;
        end else begin
          // branch_taken stays parked in the frozen EX stage until RUN
          {ctl.pc_we, ctl.ifid_we, ctl.idex_we, ctl.exmem_we} = 4'b0000;
          ctl.memwb_clr = 1'b1;
          wcnt_nxt      = wcnt + CNT_W'(1);
        end
      end
      EXC_FLUSH: begin
        ctl.pc_sel_exc = 1'b1;
        ctl.cp0_exc_we = 1'b1;
        {ctl.ifid_clr, ctl.idex_clr, ctl.exmem_clr, ctl.memwb_clr} = 4'b1111;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (rst) ctl = '0;
  end

  assign {pc_we, pc_sel_exc, ifid_we, idex_we, exmem_we, memwb_we,
          ifid_clr, idex_clr, exmem_clr, memwb_clr, cp0_exc_we, mem_err} = ctl;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctl.pc_we) stall_cnt <= stall_cnt + 32'd1;
      if (state_nxt == EXC_FLUSH && state != EXC_FLUSH) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed plan scenarios plus randomized run vs. a rule-level model.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 6;
  localparam int WM    = 4;

  // {pc_we,pc_sel_exc,ifid_we,idex_we,exmem_we,memwb_we,ifid_clr,idex_clr,exmem_clr,memwb_clr,cp0_exc_we,mem_err}
  localparam logic [11:0] V_DEF   = 12'b1011_1100_0000;
  localparam logic [11:0] V_FLUSH = 12'b0011_1111_1000;
  localparam logic [11:0] V_HOLD  = 12'b0000_0100_0100;
  localparam logic [11:0] V_EXC   = 12'b1111_1111_1110;
  localparam logic [11:0] V_BR    = 12'b1011_1110_0000;
  localparam logic [11:0] V_LU    = 12'b0001_1101_0000;
  localparam logic [11:0] V_TMO   = 12'b0011_1111_1001;

  logic clk = 1'b0, rst = 1'b1;
  logic [REG_W-1:0] id_src_a, id_src_b, ex_dest;
  logic id_use_a, id_use_b, ex_mem_read, branch_taken, mem_conflict, mem_ready, exc_valid;
  logic pc_we, pc_sel_exc, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_clr, idex_clr, exmem_clr, memwb_clr, cp0_exc_we, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  logic [11:0] obs;

  int ncmp = 0, nfail = 0;

  // model: in_wait / waited cycles / flush cycle pending, plus counter shadows
  bit m_wait, m_flush;
  int m_wn;
  int unsigned m_stall, m_fcnt;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .WAIT_MAX(WM), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_src_a(id_src_a), .id_src_b(id_src_b), .id_use_a(id_use_a),
    .id_use_b(id_use_b), .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_conflict(mem_conflict), .mem_ready(mem_ready), .exc_valid(exc_valid), .pc_we(pc_we),
    .pc_sel_exc(pc_sel_exc), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .ifid_clr(ifid_clr), .idex_clr(idex_clr), .exmem_clr(exmem_clr),
    .memwb_clr(memwb_clr), .cp0_exc_we(cp0_exc_we),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .mem_err(mem_err));

  always #5 clk = ~clk;

  assign obs = {pc_we, pc_sel_exc, ifid_we, idex_we, exmem_we, memwb_we,
                ifid_clr, idex_clr, exmem_clr, memwb_clr, cp0_exc_we, mem_err};

  function automatic bit lu();
    return ex_mem_read && ex_dest != 0 &&
           ((id_use_a && id_src_a == ex_dest) || (id_use_b && id_src_b == ex_dest));
  endfunction

  function automatic logic [11:0] model_out();
    if (rst) return 12'b0;
    if (m_flush) return V_EXC;
    if (m_wait) begin
      if (exc_valid) return V_FLUSH;
      if (mem_ready) return V_DEF;
      if (m_wn == WM) return V_TMO;
      return V_HOLD;
    end
    if (exc_valid) return V_FLUSH;
    if (mem_conflict && !mem_ready) return V_HOLD;
    if (branch_taken) return V_BR;
    if (lu()) return V_LU;
    return V_DEF;
  endfunction

  task automatic model_clear();
    m_wait = 0; m_flush = 0; m_wn = 0; m_stall = 0; m_fcnt = 0;
  endtask

  task automatic model_step();
    logic [11:0] e;
    bit go_flush;
    e = model_out();
    go_flush = 0;
    if (!e[11]) m_stall++;
    if (m_flush) m_flush = 0;
    else if (m_wait) begin
      if (exc_valid || (!mem_ready && m_wn == WM)) begin m_wait = 0; go_flush = 1; end
      else if (mem_ready) m_wait = 0;
      else m_wn++;
    end else if (exc_valid) go_flush = 1;
    else if (mem_conflict && !mem_ready) begin m_wait = 1; m_wn = 1; end
    if (go_flush) begin m_flush = 1; m_fcnt++; end
  endtask

  task automatic idle();
    id_src_a = '0; id_src_b = '0; ex_dest = '0; id_use_a = 0; id_use_b = 0; ex_mem_read = 0;
    branch_taken = 0; mem_conflict = 0; mem_ready = 0; exc_valid = 0;
  endtask

  // advance one clock; inputs change 1 time unit after the edge, checks land 2 units later
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic test_reset();
    idle();
    model_clear();
    #2;
    ncmp++;
    if (obs !== 12'b0) begin nfail++; $display("FAIL reset_outputs got=%b want=%b", obs, 12'b0); end
    @(negedge clk); rst = 0;
    #2;
    ncmp++;
    if (obs !== V_DEF) begin nfail++; $display("FAIL reset_release got=%b want=%b", obs, V_DEF); end
    tick();
  endtask

  task automatic test_load_use();
    logic [11:0] want [3];
    want = '{V_LU, V_DEF, V_DEF};
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i == 0) begin ex_mem_read = 1; ex_dest = 6'd5; id_use_a = 1; id_src_a = 6'd5; end
      if (i == 2) begin ex_mem_read = 1; ex_dest = 6'd0; id_use_a = 1; id_src_a = 6'd0; end
      #2;
      ncmp++;
      if (obs !== want[i]) begin nfail++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs, want[i]); end
      tick();
    end
    idle();
  endtask

  task automatic test_branch_vs_load_use();
    idle();
    ex_mem_read = 1; ex_dest = 6'd9; id_use_b = 1; id_src_b = 6'd9; branch_taken = 1;
    #2;
    ncmp++;
    if (obs !== V_BR) begin nfail++; $display("FAIL branch_vs_lu got=%b want=%b", obs, V_BR); end
    tick();
    idle();
  endtask

  task automatic test_mem_wait();
    for (int c = 1; c <= 5; c++) begin
      idle();
      if (c <= 4) mem_conflict = 1;
      if (c == 4) mem_ready = 1;
      #2;
      ncmp++;
      if (obs !== (c <= 3 ? V_HOLD : V_DEF)) begin
        nfail++; $display("FAIL mem_wait[c%0d] got=%b want=%b", c, obs, (c <= 3 ? V_HOLD : V_DEF));
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [11:0] w;
    for (int c = 0; c <= 6; c++) begin
      idle();
      if (c <= 4) mem_conflict = 1;
      w = (c <= 3) ? V_HOLD : (c == 4) ? V_TMO : (c == 5) ? V_EXC : V_DEF;
      #2;
      ncmp++;
      if (obs !== w) begin nfail++; $display("FAIL timeout[c%0d] got=%b want=%b", c, obs, w); end
      tick();
    end
  endtask

  task automatic test_exc_precedence();
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] f0;
    f0 = flush_cnt;
`endif
    idle();
    exc_valid = 1; mem_conflict = 1; branch_taken = 1;
    #2;
    ncmp++;
    if (obs !== V_FLUSH) begin nfail++; $display("FAIL exc_prec got=%b want=%b", obs, V_FLUSH); end
    tick();
    #2;
    ncmp++;
    if (obs !== V_EXC) begin nfail++; $display("FAIL exc_flush got=%b want=%b", obs, V_EXC); end
`ifdef HAZARD_PERF_CNT_EN
    ncmp++;
    if (flush_cnt !== f0 + 32'd1) begin nfail++; $display("FAIL flush_cnt got=%0d want=%0d", flush_cnt, f0 + 32'd1); end
`endif
    idle();
    tick();
    #2;
    ncmp++;
    if (obs !== V_DEF) begin nfail++; $display("FAIL exc_return got=%b want=%b", obs, V_DEF); end
  endtask

  task automatic test_async_reset();
    idle();
    mem_conflict = 1;
    tick(); tick();
    #2;
    ncmp++;
    if (obs !== V_HOLD) begin nfail++; $display("FAIL pre_reset_wait got=%b want=%b", obs, V_HOLD); end
    rst = 1;
    model_clear();
    #1;
    ncmp++;
    if (obs !== 12'b0) begin nfail++; $display("FAIL async_reset got=%b want=%b", obs, 12'b0); end
`ifdef HAZARD_PERF_CNT_EN
    ncmp++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      nfail++; $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
    end
`endif
    idle();
    @(negedge clk); rst = 0;
    #2;
    ncmp++;
    if (obs !== V_DEF) begin nfail++; $display("FAIL post_reset got=%b want=%b", obs, V_DEF); end
    tick();
    #2;
    ncmp++;
    if (obs !== V_DEF || cp0_exc_we !== 1'b0) begin nfail++; $display("FAIL post_reset_run got=%b want=%b", obs, V_DEF); end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] w;
    for (int n = 0; n < 400; n++) begin
      id_src_a     = REG_W'($urandom_range(3));
      id_src_b     = REG_W'($urandom_range(3));
      ex_dest      = REG_W'($urandom_range(3));
      id_use_a     = 1'($urandom_range(1));
      id_use_b     = 1'($urandom_range(1));
      ex_mem_read  = 1'($urandom_range(1));
      branch_taken = ($urandom_range(3) == 0);
      mem_conflict = ($urandom_range(3) == 0);
      mem_ready    = ($urandom_range(2) == 0);
      exc_valid    = ($urandom_range(15) == 0);
      if (mem_conflict && mem_ready) begin branch_taken = 0; ex_mem_read = 0; end
      #2;
      w = model_out();
      ncmp++;
      if (obs !== w) begin nfail++; $display("FAIL random[%0d] got=%b want=%b", n, obs, w); end
`ifdef HAZARD_PERF_CNT_EN
      ncmp++;
      if (stall_cnt !== m_stall || flush_cnt !== m_fcnt) begin
        nfail++; $display("FAIL random_cnt[%0d] got=%0d/%0d want=%0d/%0d", n, stall_cnt, flush_cnt, m_stall, m_fcnt);
      end
`endif
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_vs_load_use();
    test_mem_wait();
    test_timeout();
    test_exc_precedence();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS32 pipeline.
- Drives the write-enable and clear inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves four hazard classes:
  - load-use data hazards;
  - taken-branch redirects, with the delay slot preserved;
  - MEM-stage structural waits on shared instruction/data memory;
  - exceptions raised in MEM, including syscall.

Parameters:
- REG_W, 6, width of register indices (GPR plus HI/LO encoding); index 0 never creates a hazard.
- WAIT_MAX, 255, maximum MEM_WAIT cycles before a memory timeout is declared.
- CNT_W, 8, width of the wait counter; must hold WAIT_MAX.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_src_a  in  REG_W  ID-stage source A index
- id_src_b  in  REG_W  ID-stage source B index
- id_use_a  in  1  ID instruction reads src A
- id_use_b  in  1  ID instruction reads src B
- ex_dest  in  REG_W  EX-stage destination index
- ex_mem_read  in  1  EX instruction is a load
- branch_taken  in  1  EX resolved branch/jump taken
- mem_conflict  in  1  MEM-stage access targets instruction memory
- mem_ready  in  1  shared memory completed the MEM access
- exc_valid  in  1  MEM-stage instruction raised an exception
- pc_we  out  1  PC write enable
- pc_sel_exc  out  1  PC loads exception vector
- ifid_we, idex_we, exmem_we, memwb_we  out  1 each  pipeline register write enables
- ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  pipeline register synchronous clears
- cp0_exc_we  out  1  CP0 EPC/Cause write strobe
- mem_err  out  1  one-cycle timeout pulse

Behaviour:
- States: RUN, MEM_WAIT, EXC_FLUSH. Registered state and wait counter wcnt; all outputs are decoded from state and inputs.
- While rst is high:
  - state=RUN, wcnt=0;
  - every output forced to 0.
- Default (RUN, no event): all *_we=1, all *_clr=0, pc_sel_exc=0, cp0_exc_we=0, mem_err=0.
- load_use = ex_mem_read & ex_dest!=0 & ((id_use_a & id_src_a==ex_dest) | (id_use_b & id_src_b==ex_dest)).
- RUN priority, highest first: exc_valid > mem_conflict > branch_taken > load_use.
  1. exc_valid:
     - ifid_clr=idex_clr=exmem_clr=1;
     - pc_we=0;
     - next state EXC_FLUSH.
  2. mem_conflict & !mem_ready:
     - pc_we=ifid_we=idex_we=exmem_we=0;
     - memwb_clr=1 (bubble into WB);
     - wcnt<=1;
     - next state MEM_WAIT.
  3. mem_conflict & mem_ready: same-cycle completion, treated as no event.
  4. branch_taken:
     - ifid_clr=1 (discard the wrong-path fetch);
     - ID/EX loads normally, so the delay slot proceeds;
     - pc_we=1.
  5. load_use:
     - pc_we=0, ifid_we=0, idex_clr=1;
     - exactly one bubble; the hazard disappears the following cycle.
- MEM_WAIT:
  - Holds as in RUN rule 2; wcnt increments each cycle.
  - mem_ready=1: outputs return to the RUN default that cycle; next state RUN; wcnt<=0.
  - exc_valid=1: takes priority over mem_ready; same outputs as RUN rule 1; next state EXC_FLUSH.
  - wcnt==WAIT_MAX without ready:
    - mem_err=1 for one cycle;
    - flush as in rule 1;
    - next state EXC_FLUSH.
  - branch_taken is ignored; it stays asserted in the held EX stage and is acted on upon return to RUN.
- EXC_FLUSH (exactly 1 cycle):
  - cp0_exc_we=1, pc_sel_exc=1, pc_we=1;
  - ifid_clr=idex_clr=exmem_clr=memwb_clr=1;
  - next state RUN; inputs are ignored.
- Simultaneous load_use and branch_taken: branch wins, with no stall.
- Reset mid-MEM_WAIT or mid-EXC_FLUSH: immediate return to RUN with outputs 0; no cp0_exc_we is issued.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - adds outputs stall_cnt [31:0] and flush_cnt [31:0], both reset to 0;
  - stall_cnt increments on every cycle with pc_we=0;
  - flush_cnt increments on every entry to EXC_FLUSH;
  - both wrap at 2^32.
- Undefined: no counters and no extra ports; all other behaviour is identical.

Test Plan:
- Load-use:
  - stimulus: ex_mem_read=1, ex_dest=5, id_use_a=1, id_src_a=5 for one cycle;
  - response: pc_we=0, ifid_we=0, idex_clr=1 for exactly 1 cycle, then defaults;
  - repeat with ex_dest=0: no stall.
- Branch vs load-use:
  - stimulus: branch_taken=1 with load_use condition true;
  - response: ifid_clr=1, idex_clr=0, pc_we=1.
- Memory wait:
  - stimulus: mem_conflict=1; mem_ready rises on the 4th cycle;
  - response: pc/ifid/idex/exmem we=0 and memwb_clr=1 for 3 cycles, RUN defaults on cycle 4.
- Timeout:
  - stimulus: WAIT_MAX=4, mem_conflict=1, mem_ready=0;
  - response: mem_err pulses when wcnt=4; next cycle cp0_exc_we=1, pc_sel_exc=1, all clr=1; then RUN.
- Exception precedence:
  - stimulus: exc_valid=1 together with mem_conflict=1 and branch_taken=1;
  - response: flush of ifid/idex/exmem, next cycle EXC_FLUSH outputs;
  - with HAZARD_PERF_CNT_EN defined, flush_cnt 0→1.
- Async reset:
  - stimulus: rst asserted mid-MEM_WAIT, between clock edges;
  - response: all outputs 0 immediately; after release, RUN defaults; with HAZARD_PERF_CNT_EN defined, stall_cnt=0.
